axi4_lite_aw_master: RTL and testbench

//  Initiator side of the AXI4-Lite write address (AW) channel; drives AWVALID/AWADDR/AWPROT to a slave.

---
 rtl/axi4_lite_pkg.sv | 21 ++
 rtl/axi4_lite_cmd_fifo.sv | 50 +++++
 rtl/axi4_lite_aw_master.sv | 156 +++++++++++++++
 tb/tb_axi4_lite_aw_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared types for the AXI4-Lite write-address master
// Contents: protection width/type, default-width AW command struct, AW FSM states.
package axi4_lite_pkg;

    localparam int AXI_PROT_W = 3;
    localparam int AXI_ADDR_W = 32;

    typedef logic [AXI_PROT_W-1:0] axi_prot_t;

    // Command as queued for the AW channel at the default address width.
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        axi_prot_t             prot;
    } aw_cmd_t;

    typedef enum logic [0:0] {
        AW_IDLE  = 1'b0,
        AW_ISSUE = 1'b1
    } aw_state_t;

endpackage

// File: rtl/axi4_lite_cmd_fifo.sv
// rtl/axi4_lite_cmd_fifo.sv - command FIFO feeding the AW issue logic
// Ports:
//   ACLK, ARESETn   clock; asynchronous active-high reset (empties the FIFO)
//   i_push, i_data  write strobe and entry; caller must not push when o_full
//   i_pop           read strobe; caller must not pop when o_empty
//   o_data          head entry (combinational read of the read pointer)
//   o_full, o_empty status decoded from the pointers only
module axi4_lite_cmd_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 2
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;

    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits match; pointers wrap naturally at 2*DEPTH.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (i_push) r_mem[r_wptr[IDX_W-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[IDX_W-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                     (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]);

endmodule

// File: rtl/axi4_lite_aw_master.sv
// rtl/axi4_lite_aw_master.sv - AXI4-Lite write-address channel initiator with command queue
// Optional feature macro: AW_TIMEOUT_EN (AWREADY stall watchdog driving aw_tmo).
// Ports:
//   ACLK, ARESETn                 clock; asynchronous active-high reset
//   cmd_valid/cmd_ready           local command handshake (cmd_ready = FIFO not full)
//   cmd_addr, cmd_prot            command address and protection
//   AWVALID/AWREADY/AWADDR/AWPROT AXI4-Lite AW channel
//   aw_count                      completed AW handshakes, wraps at 16 bits
//   busy                          FIFO non-empty or AWVALID high
//   aw_tmo                        sticky AWREADY timeout flag (0 without AW_TIMEOUT_EN)
import axi4_lite_pkg::*;

module axi4_lite_aw_master #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 2,
    parameter int TMO_CYC = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [AXI_PROT_W-1:0] cmd_prot,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [AXI_PROT_W-1:0] AWPROT,
    output logic [15:0]           aw_count,
    output logic                  busy,
    output logic                  aw_tmo
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYC < 1 || TMO_CYC > 65536) begin : g_param_check
        $error("axi4_lite_aw_master: DEPTH must be a power of 2 >= 2, TMO_CYC in 1..65536");
    end

    // Address width follows ADDR_W, so the queued entry is typed locally.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        axi_prot_t         prot;
    } cmd_t;

    aw_state_t         r_state;
    aw_state_t         w_next_state;
    logic [ADDR_W-1:0] r_awaddr;
    axi_prot_t         r_awprot;
    logic [15:0]       r_aw_count;

    cmd_t w_push_data;
    cmd_t w_head;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_hs;

    assign w_push_data = '{addr: cmd_addr, prot: cmd_prot};
    assign w_push      = cmd_valid && !w_full;

    axi4_lite_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // AWVALID is pure state decode, so it never combinationally follows AWREADY.
    assign w_hs = (r_state == AW_ISSUE) && AWREADY;

    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_state <= AW_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            AW_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = AW_ISSUE;
                end
            end
            AW_ISSUE: begin
                // Refill straight from the FIFO on a handshake to sustain 1 beat/cycle.
                if (AWREADY) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_next_state = AW_IDLE;
                    end
                end
            end
            default: w_next_state = AW_IDLE;
        endcase
    end

    // Address/prot only load on a pop, so they hold through stalls and
    // keep the last issued value while idle.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_awaddr   <= '0;
            r_awprot   <= '0;
            r_aw_count <= '0;
        end else begin
            if (w_pop) begin
                r_awaddr <= w_head.addr;
                r_awprot <= w_head.prot;
            end
            if (w_hs) r_aw_count <= r_aw_count + 16'd1;
        end
    end

    assign AWVALID   = (r_state == AW_ISSUE);
    assign AWADDR    = r_awaddr;
    assign AWPROT    = r_awprot;
    assign aw_count  = r_aw_count;
    assign cmd_ready = !w_full;
    assign busy      = !w_empty || AWVALID;

`ifdef AW_TIMEOUT_EN
    localparam logic [15:0] LP_TMO_LAST = 16'(TMO_CYC - 1);

    logic [15:0] r_wait_cnt;
    logic        r_aw_tmo;

    // Flag only; AWVALID stays up so the AW handshake rules are never broken.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_wait_cnt <= '0;
            r_aw_tmo   <= 1'b0;
        end else if (!AWVALID || AWREADY) begin
            r_wait_cnt <= '0;
        end else begin
            if (r_wait_cnt == LP_TMO_LAST) r_aw_tmo <= 1'b1;
            if (r_wait_cnt != 16'hFFFF)    r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign aw_tmo = r_aw_tmo;
`else
    assign aw_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_aw_master.sv
// tb/tb_axi4_lite_aw_master.sv - scoreboard bench for axi4_lite_aw_master
`timescale 1ns/1ps
module tb_axi4_lite_aw_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_prot;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic [15:0] aw_count;
    logic        busy;
    logic        aw_tmo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [34:0] sb_q [$];

    always #5 ACLK = ~ACLK;

    axi4_lite_aw_master #(
        .ADDR_W  (32),
        .DEPTH   (2),
        .TMO_CYC (8)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_prot  (cmd_prot),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .AWPROT    (AWPROT),
        .aw_count  (aw_count),
        .busy      (busy),
        .aw_tmo    (aw_tmo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_prot  = '0;
        AWREADY   = 1'b0;
        repeat (5) tick();
        sb_q.delete();
        ARESETn = 1'b0;
        tick();
    endtask

    task automatic wait_awvalid(input string tag);
        int n;
        n = 0;
        while (!AWVALID && n < 20) begin
            tick();
            n++;
        end
        if (!AWVALID) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic push_one(input logic [31:0] a, input logic [2:0] p);
        int  n;
        logic acc;
        n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_prot  = p;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) check_eq("push_timeout", 32'd0, 32'd1);
    endtask

    // Sampled mid-cycle: values seen here are what the next rising edge captures.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            if (AWVALID && AWREADY) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    logic [34:0] e;
                    e = sb_q.pop_front();
                    check_eq("sb_awaddr", AWADDR, e[34:3]);
                    check_eq("sb_awprot", {29'd0, AWPROT}, {29'd0, e[2:0]});
                end
            end
            if (cmd_valid && cmd_ready) sb_q.push_back({cmd_addr, cmd_prot});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t4_addr [4];
        int          idx;
        logic        acc;

        // 1: reset state
        ARESETn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_prot  = '0;
        AWREADY   = 1'b0;
        repeat (5) tick();
        check_eq("rst_awvalid", {31'd0, AWVALID}, 32'd0);
        check_eq("rst_awaddr", AWADDR, 32'd0);
        check_eq("rst_awprot", {29'd0, AWPROT}, 32'd0);
        check_eq("rst_aw_count", {16'd0, aw_count}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_aw_tmo", {31'd0, aw_tmo}, 32'd0);
        ARESETn = 1'b0;
        tick();
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 2: single command, two-cycle latency, one-cycle beat
        do_reset();
        AWREADY   = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_1000;
        cmd_prot  = 3'b010;
        tick();
        cmd_valid = 1'b0;
        check_eq("t2_lat_edge1", {31'd0, AWVALID}, 32'd0);
        check_eq("t2_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("t2_awvalid", {31'd0, AWVALID}, 32'd1);
        check_eq("t2_awaddr", AWADDR, 32'h0000_1000);
        check_eq("t2_awprot", {29'd0, AWPROT}, 32'd2);
        tick();
        check_eq("t2_awvalid_low", {31'd0, AWVALID}, 32'd0);
        check_eq("t2_aw_count", {16'd0, aw_count}, 32'd1);
        check_eq("t2_hold_addr", AWADDR, 32'h0000_1000);
        AWREADY = 1'b0;

        // 3: backpressure, 10 stalled cycles then handshake
        do_reset();
        push_one(32'h0000_2000, 3'b001);
        wait_awvalid("t3_awvalid_timeout");
        for (int c = 0; c < 10; c++) begin
            check_eq("t3_stall_awvalid", {31'd0, AWVALID}, 32'd1);
            check_eq("t3_stall_awaddr", AWADDR, 32'h0000_2000);
            check_eq("t3_stall_awprot", {29'd0, AWPROT}, 32'd1);
            tick();
        end
        check_eq("t3_count_before", {16'd0, aw_count}, 32'd0);
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        check_eq("t3_aw_count", {16'd0, aw_count}, 32'd1);
        check_eq("t3_awvalid_low", {31'd0, AWVALID}, 32'd0);

        // 4: stream of 4 under backpressure, then back-to-back drain
        do_reset();
        t4_addr[0] = 32'h10;
        t4_addr[1] = 32'h20;
        t4_addr[2] = 32'h30;
        t4_addr[3] = 32'h40;
        idx = 0;
        cmd_valid = 1'b1;
        cmd_prot  = 3'b000;
        cmd_addr  = t4_addr[0];
        for (int c = 0; c < 20 && idx < 3; c++) begin
            acc = cmd_ready;
            tick();
            if (acc) begin
                idx++;
                cmd_addr = t4_addr[idx];
            end
        end
        check_eq("t4_accepted", idx, 32'd3);
        check_eq("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        tick();
        check_eq("t4_still_full", {31'd0, cmd_ready}, 32'd0);
        check_eq("t4_head_addr", AWADDR, 32'h10);
        AWREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("t4_b2b_awvalid", {31'd0, AWVALID}, 32'd1);
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) cmd_valid = 1'b0;
        end
        AWREADY = 1'b0;
        check_eq("t4_awvalid_low", {31'd0, AWVALID}, 32'd0);
        check_eq("t4_aw_count", {16'd0, aw_count}, 32'd4);
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        check_eq("t4_sb_drained", sb_q.size(), 32'd0);

        // 5: reset while a beat is stalled and another is queued
        do_reset();
        push_one(32'h0000_5000, 3'b100);
        wait_awvalid("t5_awvalid_timeout");
        push_one(32'h0000_5004, 3'b100);
        check_eq("t5_pre_awvalid", {31'd0, AWVALID}, 32'd1);
        ARESETn = 1'b1;
        #1;
        check_eq("t5_awvalid_async", {31'd0, AWVALID}, 32'd0);
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_aw_count", {16'd0, aw_count}, 32'd0);
        sb_q.delete();
        tick();
        ARESETn = 1'b0;
        AWREADY = 1'b1;
        repeat (4) tick();
        check_eq("t5_no_replay", {31'd0, AWVALID}, 32'd0);
        check_eq("t5_count_after", {16'd0, aw_count}, 32'd0);
        AWREADY = 1'b0;

        // 6: AWREADY stall watchdog
        do_reset();
        push_one(32'h0000_6000, 3'b011);
        wait_awvalid("t6_awvalid_timeout");
        check_eq("t6_tmo_start", {31'd0, aw_tmo}, 32'd0);
`ifdef AW_TIMEOUT_EN
        repeat (7) tick();
        check_eq("t6_tmo_7", {31'd0, aw_tmo}, 32'd0);
        tick();
        check_eq("t6_tmo_8", {31'd0, aw_tmo}, 32'd1);
        check_eq("t6_awvalid_held", {31'd0, AWVALID}, 32'd1);
`else
        repeat (20) tick();
        check_eq("t6_tmo_tied", {31'd0, aw_tmo}, 32'd0);
`endif
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        check_eq("t6_aw_count", {16'd0, aw_count}, 32'd1);
`ifdef AW_TIMEOUT_EN
        check_eq("t6_tmo_sticky", {31'd0, aw_tmo}, 32'd1);
`else
        check_eq("t6_tmo_after", {31'd0, aw_tmo}, 32'd0);
`endif
        check_eq("end_sb_empty", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
